// File: rtl/definitions_pkg.sv
// Shared type definitions for the RV32I core memory subsystem.
package definitions_pkg;

    // Which port, if any, is owed read data in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Unified-memory arbiter: data-first priority with a fetch starvation bound,
// request forwarding to a single-port memory and one-cycle read-data return.
module mem_arbiter
    import definitions_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,

    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,

    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned     CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic             starve_hit;
    logic             sel_if;
    logic             sel_d;
    arb_owner_e       rd_owner_q;

    assign starve_hit = (starve_cnt_q == CNT_MAX);

    // Winner selection; nothing wins while reset is held.
    always_comb begin
        sel_if = 1'b0;
        sel_d  = 1'b0;
        if (rst_i) begin
            if (d_req_i && !(if_req_i && starve_hit)) begin
                sel_d = 1'b1;
            end else if (if_req_i) begin
                sel_if = 1'b1;
            end
        end
    end

    // Forward the winning request; fetches are full-word reads.
    always_comb begin
        mem_req_o   = sel_if | sel_d;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (sel_d) begin
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (sel_if) begin
            mem_be_o    = '1;
            mem_addr_o  = if_addr_i;
        end
    end

    assign if_gnt_o = sel_if & mem_ready_i;
    assign d_gnt_o  = sel_d  & mem_ready_i;

    // Count consecutive data grants that overtook a waiting fetch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_cnt_q <= '0;
        end else if (!if_req_i || if_gnt_o) begin
            starve_cnt_q <= '0;
        end else if (d_gnt_o && !starve_hit) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end

    // Remember who issued the read accepted this cycle; stores return nothing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_owner_q <= OWN_NONE;
        end else if (if_gnt_o) begin
            rd_owner_q <= OWN_IF;
        end else if (d_gnt_o && !d_we_i) begin
            rd_owner_q <= OWN_D;
        end else begin
            rd_owner_q <= OWN_NONE;
        end
    end

    assign if_rvalid_o = (rd_owner_q == OWN_IF);
    assign d_rvalid_o  = (rd_owner_q == OWN_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              if_req, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_ready, mem_req, mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: consecutive data wins over a waiting fetch,
    // and which port expects read data this cycle.
    int m_cnt   = 0;
    bit m_if_rv = 1'b0;
    bit m_d_rv  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b1; mem_rdata = '0;
    endtask

    // Called just after a falling edge with inputs set: checks all outputs
    // against the model, advances the model, waits for the next falling edge.
    task automatic step(output bit g_if, output bit g_d);
        bit                w_if, w_d;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic [BE_W-1:0]   e_be;
        bit                e_we;
        #1;
        w_d  = d_req && !(if_req && m_cnt == int'(STARVE_MAX));
        w_if = if_req && !w_d;
        g_if = w_if && mem_ready;
        g_d  = w_d && mem_ready;
        e_addr  = w_d ? d_addr  : (w_if ? if_addr : '0);
        e_wdata = w_d ? d_wdata : '0;
        e_be    = w_d ? d_be    : (w_if ? {BE_W{1'b1}} : '0);
        e_we    = w_d ? d_we    : 1'b0;
        check_eq("if_gnt",    if_gnt,    g_if);
        check_eq("d_gnt",     d_gnt,     g_d);
        check_eq("mem_req",   mem_req,   w_if || w_d);
        check_eq("mem_addr",  mem_addr,  e_addr);
        check_eq("mem_we",    mem_we,    e_we);
        check_eq("mem_be",    mem_be,    e_be);
        check_eq("mem_wdata", mem_wdata, e_wdata);
        check_eq("if_rvalid", if_rvalid, m_if_rv);
        check_eq("d_rvalid",  d_rvalid,  m_d_rv);
        check_eq("if_rdata",  if_rdata,  m_if_rv ? mem_rdata : '0);
        check_eq("d_rdata",   d_rdata,   m_d_rv  ? mem_rdata : '0);
        if (!if_req || g_if) m_cnt = 0;
        else if (g_d && m_cnt < int'(STARVE_MAX)) m_cnt++;
        m_if_rv = g_if;
        m_d_rv  = g_d && !d_we;
        @(negedge clk);
    endtask

    initial begin
        bit       gi, gd;
        bit       if_pend, d_pend;
        bit [7:0] pat_if, pat_d;

        // Reset: requests active but nothing may be granted.
        drive_idle();
        rst_i = 1'b0;
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h80;
        #12;
        check_eq("rst_if_gnt",    if_gnt,    1'b0);
        check_eq("rst_d_gnt",     d_gnt,     1'b0);
        check_eq("rst_mem_req",   mem_req,   1'b0);
        check_eq("rst_if_rvalid", if_rvalid, 1'b0);
        check_eq("rst_d_rvalid",  d_rvalid,  1'b0);
        check_eq("rst_rdata",     {if_rdata, d_rdata}, 64'h0);
        @(negedge clk);
        rst_i = 1'b1;
        drive_idle();
        step(gi, gd);

        // Fetch only.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        #1;
        check_eq("fetch_gnt", if_gnt, 1'b1);
        check_eq("fetch_we",  mem_we, 1'b0);
        check_eq("fetch_be",  mem_be, 4'hF);
        step(gi, gd);
        if_req = 1'b0; mem_rdata = 32'h0050_0093;
        #1;
        check_eq("fetch_rvalid", if_rvalid, 1'b1);
        check_eq("fetch_rdata",  if_rdata,  32'h0050_0093);
        step(gi, gd);

        // Contention: data load wins over fetch.
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
        step(gi, gd);
        check_eq("cont_d_gnt",  gd, 1'b1);
        check_eq("cont_if_gnt", gi, 1'b0);
        d_req = 1'b0; if_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("cont_d_rdata",   d_rdata,   32'hDEAD_BEEF);
        check_eq("cont_if_rvalid", if_rvalid, 1'b0);
        step(gi, gd);

        // Starvation bound: D D D D F D.
        if_req = 1'b1; d_req = 1'b1; d_addr = 32'h104;
        pat_if = '0;
        for (int i = 0; i < 6; i++) begin
            step(gi, gd);
            pat_if[i] = gi;
        end
        check_eq("starve_pattern", pat_if, 8'b0001_0000);
        drive_idle();
        step(gi, gd);

        // Store: exact forwarding, no read response.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        #1;
        check_eq("st_mem", {mem_we, mem_be, mem_addr, mem_wdata},
                 {1'b1, 4'b0011, 32'h200, 32'h1234_5678});
        check_eq("st_gnt", d_gnt, 1'b1);
        step(gi, gd);
        drive_idle();
        #1;
        check_eq("st_no_rvalid", d_rvalid, 1'b0);
        step(gi, gd);

        // Backpressure with a waiting fetch: counter frozen while stalled.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        pat_d = '0; pat_if = '0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = !(i >= 2 && i <= 4);
            step(gi, gd);
            pat_d[i] = gd; pat_if[i] = gi;
        end
        check_eq("bp_d_pattern",  pat_d,  8'b0110_0011);
        check_eq("bp_if_pattern", pat_if, 8'b1000_0000);
        drive_idle();
        step(gi, gd);

        // Reset while a load response is outstanding.
        d_req = 1'b1; d_addr = 32'h400;
        step(gi, gd);
        d_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
        #1;
        check_eq("rr_rvalid_before", d_rvalid, 1'b1);
        rst_i = 1'b0;
        #1;
        check_eq("rr_rvalid_drop", d_rvalid, 1'b0);
        check_eq("rr_rdata_drop",  d_rdata,  32'h0);
        m_cnt = 0; m_if_rv = 1'b0; m_d_rv = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        d_req = 1'b1; d_addr = 32'h404;
        step(gi, gd);
        check_eq("rr_first_gnt", gd, 1'b1);
        d_req = 1'b0;
        step(gi, gd);
        step(gi, gd);

        // Randomized traffic honouring the hold-until-granted protocol.
        drive_idle();
        if_pend = 1'b0; d_pend = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!if_pend) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!d_pend) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) != 0;
                d_be    = BE_W'($urandom());
                d_addr  = $urandom();
                d_wdata = $urandom();
            end
            mem_ready = ($urandom_range(0, 4) != 0);
            mem_rdata = $urandom();
            step(gi, gd);
            if_pend = if_req && !gi;
            d_pend  = d_req && !gd;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the instruction-fetch port and the load/store port of the RV32I core. It arbitrates with data-first priority and a starvation bound for fetch, and forwards the winning request to the memory. It then routes the one-cycle-latency read data back to the port that issued the read. It sits between the core (fetch and load/store units) and the memory macro, replacing the separate instruction and data RAMs when the unified-memory build is selected.

## Interface
Parameters:
- `ADDR_W`, 32: address width in bits.
- `DATA_W`, 32: data width in bits; byte enables are `DATA_W/8` wide.
- `STARVE_MAX`, 4: maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `if_req_i`  in  1  fetch request; held with `if_addr_i` stable until granted.
- `if_addr_i`  in  ADDR_W  fetch address, word-aligned.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  `if_rdata_o` is valid.
- `if_rdata_o`  out  DATA_W  instruction word.
- `d_req_i`  in  1  data request; held stable with its attributes until granted.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_be_i`  in  DATA_W/8  byte enables.
- `d_addr_i`  in  ADDR_W  data address.
- `d_wdata_i`  in  DATA_W  store data.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  `d_rdata_o` is valid; loads only.
- `d_rdata_o`  out  DATA_W  load data.
- `mem_ready_i`  in  1  memory can accept a request this cycle.
- `mem_req_o`  out  1  request to memory.
- `mem_we_o`  out  1  write enable.
- `mem_be_o`  out  DATA_W/8  byte enables.
- `mem_addr_o`  out  ADDR_W  address.
- `mem_wdata_o`  out  DATA_W  write data.
- `mem_rdata_i`  in  DATA_W  read data, valid exactly one cycle after an accepted read.

## Operation
Winner selection is combinational each cycle:
- Only `d_req_i`: data wins.
- Only `if_req_i`: fetch wins.
- Both requesting: data wins, unless the starvation counter equals `STARVE_MAX`; then fetch wins.

Request forwarding:
- `mem_req_o` = winner exists.
- `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are muxed from the winner.
- A fetch forces `mem_we_o`=0 and `mem_be_o`=all-ones.
- With no winner, the `mem_*` outputs are 0.

Grants:
- `gnt` = winner && `mem_ready_i`, for the winning port only.
- The losing port, or any port while `mem_ready_i`=0, sees `gnt`=0 and must hold its request.

Starvation counter (`$clog2(STARVE_MAX+1)` bits):
- Increments on each data grant while `if_req_i`=1.
- Clears on a fetch grant, or on any cycle with `if_req_i`=0.
- Saturates at `STARVE_MAX`.

Read-return tracking:
- Owner register `rd_owner_q` takes the `arb_owner_e` value. On an accepted read it loads `OWN_IF` or `OWN_D`; otherwise it loads `OWN_NONE`.
- `if_rvalid_o` = (`rd_owner_q`==`OWN_IF`); `d_rvalid_o` = (`rd_owner_q`==`OWN_D`).
- The `rdata` output of the owning port = `mem_rdata_i`; the other port's `rdata` is 0.
- Stores never produce `rvalid`.

Back-to-back accepted requests are allowed every cycle. The response of request N and the grant of request N+1 occur in the same cycle.

## Timing
- Reset (`rst_i`=0, asynchronous): counter=0, `rd_owner_q`=`OWN_NONE`.
  - `if_rvalid_o` and `d_rvalid_o` are 0, and both `rdata` outputs are 0.
  - Grants and `mem_req_o` are 0 while `rst_i`=0, regardless of requests.
- Grant latency: 0 cycles (combinational in the request cycle, given `mem_ready_i`=1).
- Read latency: `rvalid` is asserted exactly 1 cycle after the grant, for exactly 1 cycle.
- `mem_ready_i`=0: no grant and no state change, except that the counter clears if `if_req_i`=0.
- Reset asserted mid-operation: any pending response is dropped, with no `rvalid` after reset release. The first grant is possible in the first cycle after release.
- Simultaneous requests with counter=`STARVE_MAX`: fetch granted, counter→0 next cycle.
- Counter behaviour across `mem_ready_i`=0 cycles: stalled cycles do not increment it.

## Structure
- Add `arb_owner_e` (`OWN_NONE`, `OWN_IF`, `OWN_D`; 2 bits) to `definitions_pkg`.
- Single module, no sub-modules. The winner logic, counter and owner register are small enough to keep flat.

## Test plan
- Fetch only: `if_req_i`=1, `if_addr_i`=0x0000_0010, memory returns 0x0050_0093.
  - Required: `if_gnt_o`=1 in the same cycle, with `mem_we_o`=0 and `mem_be_o`=4'hF.
  - Required: `if_rvalid_o`=1 and `if_rdata_o`=0x0050_0093 next cycle.
- Contention: both requesting; data is a load from 0x100 returning 0xDEAD_BEEF.
  - Required: `d_gnt_o`=1 and `if_gnt_o`=0.
  - Required: next cycle `d_rvalid_o`=1 with `d_rdata_o`=0xDEAD_BEEF, and `if_rvalid_o`=0.
- Starvation: `STARVE_MAX`=4, with `d_req_i` and `if_req_i` held high for 6 cycles.
  - Required: cycles 0–3 grant data, cycle 4 grants fetch, cycle 5 grants data.
- Store: `d_we_i`=1, `d_be_i`=4'b0011, `d_addr_i`=0x200, `d_wdata_i`=0x1234_5678.
  - Required: `mem_*` carry those exact values and `d_gnt_o`=1.
  - Required: `d_rvalid_o` stays 0 on the next cycle.
- Backpressure: `mem_ready_i`=0 for 3 cycles with `d_req_i`=1.
  - Required: `d_gnt_o`=0 for those 3 cycles, and the counter unchanged.
  - Required: grant in the cycle `mem_ready_i` rises.
- Reset mid-read: assert `rst_i`=0 asynchronously in the cycle after a granted load.
  - Required: `d_rvalid_o` falls immediately, and no `rvalid` appears after release.
